// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes four BCD digits onto one active-low 7-segment bus.
// Inputs are snapshotted once per frame (start of slot 0) so a frame is always coherent.
// Each digit slot begins with an anode-off guard interval to suppress ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
module seg_scan_driver #(
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic [1:0]  digit_sel,
  output logic        frame_strobe
);

  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BlankStart = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      shadow_dig_q, shadow_dig_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic             strobe_q, strobe_d;

  logic       snap;
  logic [3:0] cur_dig;
  logic       cur_dp;
  logic [6:0] cur_seg;
  logic       digit_blank;

  // Refresh counter, slot index and frame snapshot scheduling.
  always_comb begin
    snap         = (cnt_q == '0) && (sel_q == 2'd0);
    cnt_d        = cnt_q + 1'b1;
    sel_d        = sel_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end
    if (snap) begin
      shadow_dig_d = digits_in;
      shadow_dp_d  = dp_in;
    end
    strobe_d = snap;
  end

  // Select the shadow digit and decimal point for the current slot.
  always_comb begin
    cur_dig = shadow_dig_q[3:0];
    case (sel_q)
      2'd0:    cur_dig = shadow_dig_q[3:0];
      2'd1:    cur_dig = shadow_dig_q[7:4];
      2'd2:    cur_dig = shadow_dig_q[11:8];
      default: cur_dig = shadow_dig_q[15:12];
    endcase
    cur_dp = shadow_dp_q[sel_q];
  end

  // BCD to active-low segment decode; non-BCD codes blank the digit.
  always_comb begin
    cur_seg = 7'h7F;
    case (cur_dig)
      4'd0:    cur_seg = 7'h40;
      4'd1:    cur_seg = 7'h79;
      4'd2:    cur_seg = 7'h24;
      4'd3:    cur_seg = 7'h30;
      4'd4:    cur_seg = 7'h19;
      4'd5:    cur_seg = 7'h12;
      4'd6:    cur_seg = 7'h02;
      4'd7:    cur_seg = 7'h78;
      4'd8:    cur_seg = 7'h00;
      4'd9:    cur_seg = 7'h10;
      default: cur_seg = 7'h7F;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:1] lz_mask;

  // A digit is a leading zero if it and all higher digits are zero with no dp set.
  // The shadow only changes at snapshot time, so the mask is frame-stable.
  always_comb begin
    lz_mask[3] = (shadow_dig_q[15:12] == 4'd0) && !shadow_dp_q[3];
    lz_mask[2] = lz_mask[3] && (shadow_dig_q[11:8] == 4'd0) && !shadow_dp_q[2];
    lz_mask[1] = lz_mask[2] && (shadow_dig_q[7:4] == 4'd0) && !shadow_dp_q[1];
    case (sel_q)
      2'd1:    digit_blank = lz_mask[1];
      2'd2:    digit_blank = lz_mask[2];
      2'd3:    digit_blank = lz_mask[3];
      default: digit_blank = 1'b0;
    endcase
  end
`else
  assign digit_blank = 1'b0;
`endif

  // Next output values; only the anodes are gated by enable and the guard interval.
  always_comb begin
    seg_d = digit_blank ? 7'h7F : cur_seg;
    dp_d  = digit_blank ? 1'b1 : ~cur_dp;
    an_d  = 4'hF;
    if (enable && (cnt_q >= BlankStart)) begin
      an_d[sel_q] = 1'b0;
    end
  end

  // State and registered outputs with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      shadow_dig_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= 4'hF;
      strobe_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      strobe_q     <= strobe_d;
    end
  end

  assign seg_n        = seg_q;
  assign dp_n         = dp_q;
  assign an_n         = an_q;
  assign digit_sel    = sel_q;
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_CYCLES=8, BLANK_CYCLES=2.
// Timeline: after the n-th rising edge following reset release, outputs reflect
// slot ((n-1)/8)%4 at counter position (n-1)%8, and digit_sel equals (n/8)%4.
module tb_seg_scan_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [1:0]  digit_sel;
  logic        frame_strobe;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  seg_scan_driver #(
    .REFRESH_CYCLES(8),
    .BLANK_CYCLES  (2),
    .CNT_W         (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .digit_sel   (digit_sel),
    .frame_strobe(frame_strobe)
  );

  always #5 clock = ~clock;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LzSeg = 7'h7F;
`else
  localparam logic [6:0] LzSeg = 7'h40;
`endif

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp;
    int          slot;
    logic [6:0]  seg;
    logic        dpn;
    logic [3:0]  an;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance to the n-th edge after reset release and sample 1 time unit later.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock);
      cyc++;
    end
    #1;
  endtask

  task automatic do_reset(input logic [15:0] d, input logic [3:0] p);
    reset     = 1'b1;
    enable    = 1'b1;
    digits_in = d;
    dp_in     = p;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_an", 16'(an_n), 16'hF);
    chk("rst_seg", 16'(seg_n), 16'h7F);
    chk("rst_dp", 16'(dp_n), 16'h1);
    chk("rst_strobe", 16'(frame_strobe), 16'h0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p, input int s,
                              input logic [6:0] sg, input logic dn, input logic [3:0] a);
    vec_t v;
    v.dig = d; v.dp = p; v.slot = s; v.seg = sg; v.dpn = dn; v.an = a;
    return v;
  endfunction

  initial begin
    logic [3:0] exp_an;
    int prev;

    vecs[0]  = mk(16'h4321, 4'b0000, 0, 7'h79, 1'b1, 4'hE);
    vecs[1]  = mk(16'h4321, 4'b0000, 1, 7'h24, 1'b1, 4'hD);
    vecs[2]  = mk(16'h4321, 4'b0000, 2, 7'h30, 1'b1, 4'hB);
    vecs[3]  = mk(16'h4321, 4'b0000, 3, 7'h19, 1'b1, 4'h7);
    vecs[4]  = mk(16'h00A0, 4'b0010, 0, 7'h40, 1'b1, 4'hE);
    vecs[5]  = mk(16'h00A0, 4'b0010, 1, 7'h7F, 1'b0, 4'hD);
    vecs[6]  = mk(16'h00A0, 4'b0010, 2, LzSeg, 1'b1, 4'hB);
    vecs[7]  = mk(16'h00A0, 4'b0010, 3, LzSeg, 1'b1, 4'h7);
    vecs[8]  = mk(16'h9876, 4'b0000, 0, 7'h02, 1'b1, 4'hE);
    vecs[9]  = mk(16'h9876, 4'b0000, 1, 7'h78, 1'b1, 4'hD);
    vecs[10] = mk(16'h9876, 4'b0000, 2, 7'h00, 1'b1, 4'hB);
    vecs[11] = mk(16'h9876, 4'b0000, 3, 7'h10, 1'b1, 4'h7);
    vecs[12] = mk(16'hE5CF, 4'b1001, 0, 7'h7F, 1'b0, 4'hE);
    vecs[13] = mk(16'hE5CF, 4'b1001, 1, 7'h7F, 1'b1, 4'hD);
    vecs[14] = mk(16'hE5CF, 4'b1001, 2, 7'h12, 1'b1, 4'hB);
    vecs[15] = mk(16'hE5CF, 4'b1001, 3, 7'h7F, 1'b0, 4'h7);

    // Table: one slot per vector, sampled mid-way through the active window.
    for (int i = 0; i < 16; i++) begin
      do_reset(vecs[i].dig, vecs[i].dp);
      goto(8 * vecs[i].slot + 6);
      chk("vec_seg", 16'(seg_n), 16'(vecs[i].seg));
      chk("vec_dp", 16'(dp_n), 16'(vecs[i].dpn));
      chk("vec_an", 16'(an_n), 16'(vecs[i].an));
      chk("vec_sel", 16'(digit_sel), 16'(vecs[i].slot));
    end

    // Scan timing over more than one frame: guard interval, one-hot anodes, strobe.
    do_reset(16'h4321, 4'b0000);
    for (int n = 1; n <= 40; n++) begin
      goto(n);
      prev   = n - 1;
      exp_an = 4'hF;
      if ((prev % 8) >= 2) exp_an = ~(4'b0001 << ((prev / 8) % 4));
      chk("scan_an", 16'(an_n), 16'(exp_an));
      chk("scan_sel", 16'(digit_sel), 16'((n / 8) % 4));
      chk("scan_strobe", 16'(frame_strobe), 16'((n == 1) || (n == 33)));
    end

    // Coherency: input change mid-frame is held off until the next snapshot.
    do_reset(16'h1234, 4'b0000);
    goto(6);
    chk("coh_s0", 16'(seg_n), 16'h19);
    goto(18);
    digits_in = 16'h5678;
    goto(22);
    chk("coh_s2", 16'(seg_n), 16'h24);
    goto(30);
    chk("coh_s3", 16'(seg_n), 16'h79);
    goto(33);
    chk("coh_strobe", 16'(frame_strobe), 16'h1);
    goto(38);
    chk("coh_new0", 16'(seg_n), 16'h00);
    goto(46);
    chk("coh_new1", 16'(seg_n), 16'h78);

    // Enable drop during slot 1, then reset during slot 2.
    do_reset(16'h4321, 4'b0000);
    goto(12);
    chk("en_on_an", 16'(an_n), 16'hD);
    enable = 1'b0;
    goto(13);
    chk("en_off_an", 16'(an_n), 16'hF);
    chk("en_off_seg", 16'(seg_n), 16'h24);
    goto(18);
    chk("en_off_sel", 16'(digit_sel), 16'h2);
    chk("en_off_an2", 16'(an_n), 16'hF);
    enable = 1'b1;
    goto(22);
    chk("en_back_an", 16'(an_n), 16'hB);
    reset = 1'b1;
    goto(23);
    chk("mid_rst_an", 16'(an_n), 16'hF);
    chk("mid_rst_seg", 16'(seg_n), 16'h7F);
    chk("mid_rst_dp", 16'(dp_n), 16'h1);
    chk("mid_rst_sel", 16'(digit_sel), 16'h0);
    chk("mid_rst_strobe", 16'(frame_strobe), 16'h0);
    reset = 1'b0;
    cyc   = 0;
    goto(1);
    chk("restart_strobe", 16'(frame_strobe), 16'h1);
    goto(6);
    chk("restart_an", 16'(an_n), 16'hE);
    chk("restart_seg", 16'(seg_n), 16'h79);

`ifdef LEADING_ZERO_BLANK_EN
    // Leading zero blanking, with and without a decimal point on digit 3.
    do_reset(16'h0070, 4'b0000);
    goto(6);
    chk("lz_s0", 16'(seg_n), 16'h40);
    goto(14);
    chk("lz_s1", 16'(seg_n), 16'h78);
    goto(22);
    chk("lz_s2", 16'(seg_n), 16'h7F);
    chk("lz_s2_an", 16'(an_n), 16'hB);
    goto(30);
    chk("lz_s3", 16'(seg_n), 16'h7F);
    chk("lz_s3_dp", 16'(dp_n), 16'h1);
    do_reset(16'h0070, 4'b1000);
    goto(22);
    chk("lzdp_s2", 16'(seg_n), 16'h40);
    goto(30);
    chk("lzdp_s3", 16'(seg_n), 16'h40);
    chk("lzdp_s3_dp", 16'(dp_n), 16'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the four-digit BCD stopwatch counters.
- Takes four BCD digits plus decimal-point requests and time-multiplexes them onto one shared active-low 7-segment bus with one-hot active-low digit anodes.
- Snapshots inputs once per frame so a displayed frame never mixes digits from two different counter states.
- Inserts an anode-off guard at each digit change to suppress ghosting.

Parameters:
- REFRESH_CYCLES, 50000: clock cycles per digit slot; minimum 4.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; minimum 2; must be less than REFRESH_CYCLES.
- CNT_W, 16: refresh counter width; must satisfy 2^CNT_W >= REFRESH_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  display on; when low, all anodes are forced off
- digits_in  in  16  BCD digits: [3:0]=digit0 (least significant) ... [15:12]=digit3
- dp_in  in  4  decimal-point request per digit, bit n = digit n
- seg_n  out  7  active-low segments, [0]=a ... [6]=g
- dp_n  out  1  active-low decimal point
- an_n  out  4  active-low anode enables, bit n = digit n
- digit_sel  out  2  index of the current slot
- frame_strobe  out  1  one-cycle pulse when a snapshot is taken

Behaviour:
- Reset values: cnt=0, digit_sel=0, shadow digits=0, shadow dp=0, seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_strobe=0.
- Refresh counter cnt:
  - counts 0..REFRESH_CYCLES-1 every cycle, then wraps to 0;
  - on each wrap, digit_sel increments mod 4 (sequence 0,1,2,3,0).
- Snapshot:
  - in any cycle with cnt==0 and digit_sel==0, including the first cycle after reset deasserts, shadow registers load digits_in/dp_in;
  - frame_strobe=1 in the following cycle only.
  - Input changes at any other time have no effect until the next snapshot.
- Outputs are registered: values in cycle t+1 are a function of cnt, digit_sel and shadow in cycle t.
- an_n:
  - the bit for digit_sel is low only when cnt >= BLANK_CYCLES and enable=1;
  - all other bits are high;
  - never more than one bit is low.
- seg_n decode of shadow digit[digit_sel], hex with bit[6]=g:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10;
  - codes 10–15 = 7F (blank).
- dp_n = ~shadow_dp[digit_sel].
- seg_n and dp_n update regardless of enable; only an_n is gated.
- Reset asserted mid-frame: all state returns to reset values at the next edge; the scan restarts at digit 0 with a fresh snapshot.
- Reset has priority over every other input.
- enable toggling does not disturb cnt, digit_sel or the snapshot schedule.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined, the block computes from the shadow, at snapshot time, a blank mask for digits 3, 2 and 1:
  - digit n is blanked if it and every higher digit equal 0 and none of those digits has its shadow dp set;
  - digit 0 is never blanked.
- A blanked digit drives seg_n=7F and dp_n=1; an_n timing is unchanged.
- When not defined, all digits are always decoded, and the mask logic is not present.

Test Plan:
- Reset: hold reset 3 cycles, release -> an_n=F, seg_n=7F, dp_n=1 during reset; frame_strobe pulses exactly once, 2 cycles after release.
- Scan timing (REFRESH_CYCLES=8, BLANK_CYCLES=2, enable=1, digits_in=16'h4321) -> each slot shows 2 cycles all-off then 6 cycles active. Per slot, in order:
  - an_n=E, seg_n=79;
  - an_n=D, seg_n=24;
  - an_n=B, seg_n=30;
  - an_n=7, seg_n=19;
  - the pattern then repeats.
- Coherency: change digits_in from 16'h1234 to 16'h5678 during slot 2 -> slots 2–3 still show 2 and 1; the new value is displayed only after the next frame_strobe.
- Invalid BCD plus dp: digits_in=16'h00A0, dp_in=4'b0010 -> slot 1 shows seg_n=7F with dp_n=0; other slots show dp_n=1.
- Enable and reset mid-frame: drop enable during slot 1 -> an_n=F immediately on the next registered update while digit_sel still advances. Assert reset during slot 2 -> next cycle all outputs return to reset values, digit_sel=0.
- With LEADING_ZERO_BLANK_EN defined, digits_in=16'h0070, dp_in=0:
  - slots 3 and 2 show seg_n=7F;
  - slot 1 shows 78;
  - slot 0 shows 40.
  
  With dp_in=4'b1000, slot 3 shows seg_n=40 with dp_n=0, and slot 2 also shows 40.
